// File: rtl/vend_pkg.sv
// Shared constants for the vending controller: coin/note denominations, FSM
// state encodings, error codes and the denomination lookup.
package vend_pkg;

  localparam int unsigned NUM_DENOM = 5;
  localparam int unsigned DENOM_W   = 7;
  localparam int unsigned DENOM_VAL [NUM_DENOM] = '{5, 10, 20, 50, 100};

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_CREDIT = 3'd1;
  localparam logic [ST_W-1:0] ST_CHECK  = 3'd2;
  localparam logic [ST_W-1:0] ST_VEND   = 3'd3;
  localparam logic [ST_W-1:0] ST_CHANGE = 3'd4;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STOCK = 2'd1,
    ERR_FUNDS = 2'd2,
    ERR_SEL   = 2'd3
  } err_code_e;

  // Value of denomination index; out-of-range indices are worth nothing.
  function automatic logic [DENOM_W-1:0] denom_value(input logic [2:0] idx);
    logic [DENOM_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (idx == 3'(i)) v = DENOM_W'(DENOM_VAL[i]);
    end
    return v;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change selector: presents the largest note not exceeding the
// remaining credit and advances to the next note right after each transfer.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic [CREDIT_W-1:0] remaining,
  input  logic                note_ready,
  output logic                note_valid,
  output logic [2:0]          note_idx,
  output logic                fire_c,
  output logic [CREDIT_W-1:0] note_val_c
);

  logic [CREDIT_W-1:0] sel_rem;

  function automatic logic [2:0] greedy(input logic [CREDIT_W-1:0] rem);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (rem >= CREDIT_W'(DENOM_VAL[i])) idx = 3'(i);
    end
    return idx;
  endfunction

  // Remaining credit once the note on offer (if any) has been taken.
  always_comb begin
    fire_c     = note_valid && note_ready;
    note_val_c = CREDIT_W'(denom_value(note_idx));
    sel_rem    = note_valid ? (remaining - note_val_c) : remaining;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_valid <= 1'b0;
      note_idx   <= 3'd0;
    end else if (!active) begin
      note_valid <= 1'b0;
      note_idx   <= 3'd0;
    end else if (!note_valid || note_ready) begin
      note_valid <= (sel_rem != '0);
      note_idx   <= (sel_rem != '0) ? greedy(sel_rem) : 3'd0;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Multi-item vending controller: coin credit, programmable price/stock table,
// per-session repeated purchases and greedy note-by-note change return.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_ITEMS),
  parameter int unsigned QTY_W       = 4,
  parameter int unsigned PRICE_W     = 12,
  parameter int unsigned STOCK_W     = 8,
  parameter int unsigned CREDIT_W    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [2:0]          coin_sel,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_item,
  input  logic [QTY_W-1:0]    sel_qty,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_item,
  input  logic [PRICE_W-1:0]  cfg_price,
  input  logic [STOCK_W-1:0]  cfg_stock,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_item,
  output logic [QTY_W-1:0]    vend_qty,
  input  logic                vend_ready,
  output logic                note_valid,
  output logic [2:0]          note_idx,
  input  logic                note_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic                busy
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned COST_W = PRICE_W + QTY_W;
  localparam int unsigned CMP_W  = (COST_W > CREDIT_W) ? COST_W : CREDIT_W;
  localparam int unsigned SQ_W   = (STOCK_W > QTY_W) ? STOCK_W : QTY_W;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);

  logic [ST_W-1:0]     state_q, state_d;
  logic [TMR_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    cap_item_q, cap_item_d;
  logic [QTY_W-1:0]    cap_qty_q, cap_qty_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                vend_valid_d, err_valid_d, coin_reject_d, busy_d;
  logic [IDX_W-1:0]    vend_item_d;
  logic [QTY_W-1:0]    vend_qty_d;
  logic [1:0]          err_code_d;

  logic [PRICE_W-1:0]  price_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];

  logic [SUM_W-1:0]    coin_sum;
  logic                coin_ok, cfg_ok, item_ok, stock_lo, funds_lo, buy;
  logic [IDX_W-1:0]    item_idx;
  logic [PRICE_W-1:0]  cur_price;
  logic [STOCK_W-1:0]  cur_stock;
  logic [COST_W-1:0]   cost;
  logic                fire_c;
  logic [CREDIT_W-1:0] note_val_c;

  // Coin acceptance, config qualification and purchase checks on the captured selection.
  always_comb begin
    coin_sum  = SUM_W'(credit) + SUM_W'(denom_value(coin_sel));
    coin_ok   = coin_valid && (coin_sel <= 3'd4) && !coin_sum[CREDIT_W]
                && ((state_q == ST_IDLE) || (state_q == ST_CREDIT));
    cfg_ok    = cfg_we && (state_q == ST_IDLE) && (32'(cfg_item) < NUM_ITEMS)
                && ((cfg_price % PRICE_W'(5)) == '0);
    item_ok   = 32'(cap_item_q) < NUM_ITEMS;
    item_idx  = item_ok ? cap_item_q : '0;
    cur_price = price_q[item_idx];
    cur_stock = stock_q[item_idx];
    cost      = COST_W'(cur_price) * COST_W'(cap_qty_q);
    stock_lo  = SQ_W'(cur_stock) < SQ_W'(cap_qty_q);
    funds_lo  = CMP_W'(cost) > CMP_W'(credit);
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit;
    cnt_d         = '0;
    cap_item_d    = cap_item_q;
    cap_qty_d     = cap_qty_q;
    vend_valid_d  = vend_valid;
    vend_item_d   = vend_item;
    vend_qty_d    = vend_qty;
    err_valid_d   = 1'b0;
    err_code_d    = ERR_NONE;
    coin_reject_d = coin_valid && !coin_ok;
    buy           = 1'b0;
    if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) state_d = ST_CREDIT;
      end
      ST_CREDIT: begin
        cnt_d = (coin_ok || sel_valid) ? '0 : cnt_q + TMR_W'(1);
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (sel_valid) begin
          state_d    = ST_CHECK;
          cap_item_d = sel_item;
          cap_qty_d  = sel_qty;
        end else if (!coin_ok && (cnt_q == TMR_W'(TIMEOUT_CYC - 1))) begin
          state_d = ST_CHANGE;
        end
      end
      ST_CHECK: begin
        if (!item_ok || (cap_qty_q == '0)) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_SEL;
          state_d     = ST_CREDIT;
        end else if (stock_lo) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_STOCK;
          state_d     = ST_CREDIT;
        end else if (funds_lo) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_FUNDS;
          state_d     = ST_CREDIT;
        end else begin
          buy          = 1'b1;
          credit_d     = credit - CREDIT_W'(cost);
          vend_valid_d = 1'b1;
          vend_item_d  = cap_item_q;
          vend_qty_d   = cap_qty_q;
          state_d      = ST_VEND;
        end
      end
      ST_VEND: begin
        if (vend_ready && vend_valid) begin
          vend_valid_d = 1'b0;
          vend_item_d  = '0;
          vend_qty_d   = '0;
          state_d      = (credit != '0) ? ST_CREDIT : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (fire_c) credit_d = credit - note_val_c;
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_CREDIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      credit      <= '0;
      cnt_q       <= '0;
      cap_item_q  <= '0;
      cap_qty_q   <= '0;
      vend_valid  <= 1'b0;
      vend_item   <= '0;
      vend_qty    <= '0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      cnt_q       <= cnt_d;
      cap_item_q  <= cap_item_d;
      cap_qty_q   <= cap_qty_d;
      vend_valid  <= vend_valid_d;
      vend_item   <= vend_item_d;
      vend_qty    <= vend_qty_d;
      err_valid   <= err_valid_d;
      err_code    <= err_code_d;
      coin_reject <= coin_reject_d;
      busy        <= busy_d;
    end
  end

  // Price/stock table: written by config while idle, stock drawn down on purchase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      price_q[cfg_item] <= cfg_price;
      stock_q[cfg_item] <= cfg_stock;
    end else if (buy) begin
      stock_q[item_idx] <= cur_stock - STOCK_W'(cap_qty_q);
    end
  end

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == ST_CHANGE),
    .remaining  (credit),
    .note_ready (note_ready),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .fire_c     (fire_c),
    .note_val_c (note_val_c)
  );

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: a table of per-cycle input/expected
// output records plus hand-written overflow, handshake, timeout and reset sequences.
module tb_vend_controller;

  localparam int unsigned NUM_ITEMS   = 6;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned QTY_W       = 4;
  localparam int unsigned PRICE_W     = 12;
  localparam int unsigned STOCK_W     = 8;
  localparam int unsigned CREDIT_W    = 16;
  localparam int unsigned TIMEOUT_CYC = 50;

  logic                clk = 1'b0;
  logic                rst;
  logic                coin_valid, coin_reject, sel_valid, cancel, cfg_we;
  logic [2:0]          coin_sel;
  logic [IDX_W-1:0]    sel_item, cfg_item, vend_item;
  logic [QTY_W-1:0]    sel_qty, vend_qty;
  logic [PRICE_W-1:0]  cfg_price;
  logic [STOCK_W-1:0]  cfg_stock;
  logic                vend_valid, vend_ready, note_valid, note_ready;
  logic [2:0]          note_idx;
  logic [CREDIT_W-1:0] credit;
  logic                err_valid, busy;
  logic [1:0]          err_code;

  vend_controller #(
    .NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W),
    .STOCK_W(STOCK_W), .CREDIT_W(CREDIT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .coin_reject(coin_reject), .sel_valid(sel_valid), .sel_item(sel_item),
    .sel_qty(sel_qty), .cancel(cancel), .cfg_we(cfg_we), .cfg_item(cfg_item),
    .cfg_price(cfg_price), .cfg_stock(cfg_stock), .vend_valid(vend_valid),
    .vend_item(vend_item), .vend_qty(vend_qty), .vend_ready(vend_ready),
    .note_valid(note_valid), .note_idx(note_idx), .note_ready(note_ready),
    .credit(credit), .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cv, cs, sv, si, sq, cn, vr, nr;
    int cr, rej, vv, vi, vq, nv, ni, ev, ec, bz;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic int denom_m(input int i);
    int d [5] = '{5, 10, 20, 50, 100};
    return d[i];
  endfunction

  function automatic int greedy_m(input int r);
    if (r >= 100) return 4;
    if (r >= 50)  return 3;
    if (r >= 20)  return 2;
    if (r >= 10)  return 1;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    coin_valid = 0; coin_sel = 0; sel_valid = 0; sel_item = 0; sel_qty = 0;
    cancel = 0; cfg_we = 0; cfg_item = 0; cfg_price = 0; cfg_stock = 0;
    vend_ready = 0; note_ready = 0;
  endtask

  task automatic drive(input vec_t t);
    coin_valid = t.cv[0]; coin_sel = 3'(t.cs); sel_valid = t.sv[0];
    sel_item = IDX_W'(t.si); sel_qty = QTY_W'(t.sq); cancel = t.cn[0];
    vend_ready = t.vr[0]; note_ready = t.nr[0];
  endtask

  task automatic cfg(input int item, input int price, input int stock);
    cfg_we = 1; cfg_item = IDX_W'(item); cfg_price = PRICE_W'(price); cfg_stock = STOCK_W'(stock);
    step();
    cfg_we = 0;
  endtask

  task automatic check_outs(input string name, input vec_t e);
    nvec++;
    if (int'(credit) != e.cr || int'(coin_reject) != e.rej || int'(vend_valid) != e.vv ||
        int'(vend_item) != e.vi || int'(vend_qty) != e.vq || int'(note_valid) != e.nv ||
        int'(note_idx) != e.ni || int'(err_valid) != e.ev || int'(err_code) != e.ec ||
        int'(busy) != e.bz) begin
      nerr++;
      $display("FAIL %s: got cr=%0d rej=%0d vv=%0d vi=%0d vq=%0d nv=%0d ni=%0d ev=%0d ec=%0d bz=%0d want cr=%0d rej=%0d vv=%0d vi=%0d vq=%0d nv=%0d ni=%0d ev=%0d ec=%0d bz=%0d",
               name, credit, coin_reject, vend_valid, vend_item, vend_qty, note_valid,
               note_idx, err_valid, err_code, busy, e.cr, e.rej, e.vv, e.vi, e.vq, e.nv,
               e.ni, e.ev, e.ec, e.bz);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zero;
    int   rem, bad, notes, k, stable;
    logic xfer, done;
    zero = '{default: 0};
    idle_in();
    rst = 0;
    #3;
    check_outs("reset", zero);
    @(negedge clk);
    rst = 1;
    step();

    cfg(2, 45, 3);
    cfg(1, 75, 5);
    cfg(3, 10, 1);
    cfg(4, 7, 9);

    //            cv cs sv si sq cn vr nr    cr  rej vv vi vq nv ni ev ec bz
    tbl.push_back('{1, 3, 0, 0, 0, 0, 0, 0,   50, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0,   70, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 2, 1, 0, 0, 0,   70, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,   25, 0, 1, 2, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,   25, 1, 1, 2, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0,   25, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,   25, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,   25, 0, 0, 0, 0, 1, 2, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,   25, 0, 0, 0, 0, 1, 2, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,    5, 0, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 4, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 2, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{0, 0, 1, 3, 2, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 6, 1, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 2, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 4, 1, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 0,  110, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,   35, 0, 1, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0,   35, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 0, 0,   45, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,   45, 0, 0, 0, 0, 1, 2, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1,   25, 1, 0, 0, 0, 1, 2, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,    5, 0, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0,   10, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 2, 1, 1, 0, 0,   10, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,   10, 0, 0, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      check_outs($sformatf("vec%0d", i), tbl[i]);
    end
    idle_in();

    // Fill credit close to the top of the accumulator, then probe overflow rejection.
    coin_valid = 1;
    coin_sel = 3'd4;
    for (int i = 0; i < 654; i++) step();
    coin_sel = 3'd3; step();
    coin_sel = 3'd2; step();
    coin_sel = 3'd1; step();
    chk("fill_credit", int'(credit), 65480);
    coin_sel = 3'd4; step();
    chk("ovf_reject", int'(coin_reject), 1);
    chk("ovf_credit", int'(credit), 65480);
    coin_sel = 3'd3; step();
    chk("near_max", int'(credit), 65530);
    coin_sel = 3'd1; step();
    chk("ovf_reject2", int'(coin_reject), 1);
    chk("ovf_credit2", int'(credit), 65530);
    coin_valid = 0;

    // Long vend_ready stall with stable payload.
    sel_valid = 1; sel_item = 3'd2; sel_qty = 4'd1;
    step();
    sel_valid = 0;
    step();
    chk("big_vend_valid", int'(vend_valid), 1);
    chk("big_vend_credit", int'(credit), 65485);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(vend_valid === 1'b1 && vend_item === 3'd2 && vend_qty === 4'd1)) stable = 0;
    end
    chk("vend_hold_stable", stable, 1);
    vend_ready = 1; step(); vend_ready = 0;
    chk("vend_exit", int'(vend_valid), 0);

    // Drain the large credit with an irregular note_ready pattern.
    cancel = 1; step(); cancel = 0;
    rem = 65485; bad = 0; notes = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      note_ready = (c % 3 != 2);
      if (note_valid && int'(note_idx) != greedy_m(rem)) bad++;
      xfer = note_valid && note_ready;
      step();
      if (xfer) begin
        rem -= denom_m(greedy_m(rem));
        notes++;
      end
      if (!busy) done = 1;
    end
    note_ready = 0;
    chk("drain_done", int'(done), 1);
    chk("drain_note_idx", bad, 0);
    chk("drain_notes", notes, 658);
    chk("drain_rem", rem, 0);
    chk("drain_credit", int'(credit), 0);

    // Idle timeout with 35 credit.
    coin_valid = 1;
    coin_sel = 3'd2; step();
    coin_sel = 3'd1; step();
    coin_sel = 3'd0; step();
    coin_valid = 0;
    chk("to_credit", int'(credit), 35);
    k = 0;
    while (!busy && k < 200) begin
      step();
      k++;
    end
    chk("timeout_cycles", k, TIMEOUT_CYC);
    step();
    chk("to_note1_valid", int'(note_valid), 1);
    chk("to_note1_idx", int'(note_idx), 2);
    note_ready = 1; step(); note_ready = 0;
    chk("to_note2_idx", int'(note_idx), 1);
    chk("to_note2_credit", int'(credit), 15);

    // Asynchronous reset in the middle of change return.
    #2 rst = 0;
    #1;
    check_outs("rst_mid_change", zero);
    @(negedge clk);
    rst = 1;
    step();
    coin_valid = 1; coin_sel = 3'd0; step(); coin_valid = 0;
    cfg(2, 45, 3);
    sel_valid = 1; sel_item = 3'd2; sel_qty = 4'd1;
    step();
    sel_valid = 0;
    step();
    chk("post_rst_err_valid", int'(err_valid), 1);
    chk("post_rst_err_code", int'(err_code), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Parametrised multi-item vending controller, successor to the fixed five-product machine. It accepts coins into a running credit and serves any number of purchases per session against a runtime-programmable price/stock table. It returns change one note at a time over a valid/ready handshake. It sits between the coin acceptor/keypad front end and the dispense and note-return mechanisms.

## Interface
- NUM_ITEMS, 8, number of products (2..32); IDX_W = $clog2(NUM_ITEMS)
- QTY_W, 4, quantity field width
- PRICE_W, 12, unit price width
- STOCK_W, 8, per-item stock counter width
- CREDIT_W, 16, credit accumulator width
- TIMEOUT_CYC, 1000, idle cycles with credit before auto-return
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- coin_valid  in  1  one-cycle coin pulse
- coin_sel  in  3  denomination index 0..4 = 5,10,20,50,100
- coin_reject  out  1  pulse: coin not credited, returned physically
- sel_valid  in  1  selection pulse
- sel_item  in  IDX_W  item index
- sel_qty  in  QTY_W  quantity
- cancel  in  1  end session, return credit
- cfg_we  in  1  write price and stock for cfg_item
- cfg_item  in  IDX_W; cfg_price  in  PRICE_W; cfg_stock  in  STOCK_W
- vend_valid  out  1; vend_item  out  IDX_W; vend_qty  out  QTY_W; vend_ready  in  1
- note_valid  out  1; note_idx  out  3  denomination index; note_ready  in  1
- credit  out  CREDIT_W  current credit
- err_valid  out  1  one-cycle pulse; err_code  out  2  1 out-of-stock, 2 insufficient funds, 3 invalid selection
- busy  out  1  high outside IDLE/CREDIT

## Operation
- States: IDLE (credit 0), CREDIT, CHECK, VEND, CHANGE.
- Coins are accepted only in IDLE/CREDIT. credit += DENOM[coin_sel]. A coin is rejected (coin_reject, no credit change) if coin_sel > 4, if the sum would exceed 2^CREDIT_W-1, or if the state is CHECK/VEND/CHANGE.
- IDLE -> CREDIT on the first accepted coin.
- CREDIT + sel_valid: capture item/qty and go to CHECK.
- CHECK (1 cycle), in priority order:
  - item >= NUM_ITEMS or qty == 0 -> err 3
  - stock < qty -> err 1
  - price*qty (PRICE_W+QTY_W bits, no truncation) > credit -> err 2
  - On error: err pulse, return to CREDIT, credit unchanged.
  - Otherwise: stock -= qty, credit -= cost, go to VEND.
- VEND: hold vend_valid with stable item/qty until vend_ready is sampled high. Then go to CREDIT if credit > 0, else IDLE. The session allows repeated purchases.
- cancel in CREDIT, or TIMEOUT_CYC consecutive cycles in CREDIT without an accepted coin or selection, -> CHANGE.
- CHANGE: greedy. note_idx = largest denomination <= remaining credit. On the note_valid && note_ready transfer, credit -= value. Go to IDLE when credit reaches 0.
- Exact change is guaranteed: cfg_we is ignored when cfg_price is not a multiple of 5. cfg_we is honoured only in IDLE; elsewhere it is ignored.
- Same-cycle events in CREDIT:
  - coin + sel: the coin is credited first; CHECK sees the new credit.
  - cancel + sel or cancel + coin: cancel wins, sel is dropped, and the coin is still credited then refunded.
- Reset: state IDLE, credit 0, all prices and stock 0, all outputs 0. Reset mid-VEND/CHANGE aborts with no further handshake.

## Timing
- Coin at cycle t -> credit updated at t+1.
- sel at t -> CHECK at t+1 -> vend_valid or err_valid at t+2.
- vend_ready at t -> VEND exit at t+1.
- First note_valid appears the cycle after entering CHANGE. After each transfer, the next note is presented on the following cycle (1 note/cycle maximum).
- Timeout counter resets on every accepted coin or selection. Transition fires on the cycle the count reaches TIMEOUT_CYC.
- All outputs are registered.

## Structure
- vend_pkg:
  - DENOM_VAL[5] = {5,10,20,50,100}
  - state enum
  - err_code enum
  - function denom_value(idx)
- Sub-module vend_change_gen: combinational greedy selector (remaining -> note_idx) plus note handshake register.
- Price/stock storage: flop arrays indexed by item. Optional RAM is a later change.

## Test plan
- Config item 2 at price 45, stock 3. Insert 50+20. Select item 2, qty 1 -> vend 2/1, credit 25. cancel -> notes 20, 5, then IDLE.
- Credit 100. Select item price 75, qty 2 -> err 2, credit still 100, stock unchanged.
- Stock 1, select qty 2 -> err 1. sel_item = NUM_ITEMS -> err 3. qty 0 -> err 3.
- Credit at 2^CREDIT_W-50, insert 100 -> coin_reject, credit unchanged. Insert a coin during VEND -> coin_reject.
- Hold vend_ready low 10 cycles -> vend_valid and payload stable. Hold note_ready low -> note_idx stable.
- Credit 35, no activity for TIMEOUT_CYC cycles -> CHANGE, notes 20, 10, 5. Assert rst mid-CHANGE -> all outputs 0, price/stock 0.
